// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer and the ALU it drives.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    // ALU command encoding; codes above ALU_CMD_MAX are rejected by the sequencer
    typedef enum logic [3:0] {
        CMD_AND  = 4'd0,
        CMD_OR   = 4'd1,
        CMD_XOR  = 4'd2,
        CMD_NOT  = 4'd3,
        CMD_ADDU = 4'd4,
        CMD_ADDS = 4'd5,
        CMD_SUBU = 4'd6
    } alu_cmd_e;

    localparam logic [3:0] ALU_CMD_MAX = 4'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } seq_state_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU: logic ops, unsigned/signed add and unsigned subtract.
// Latency: zero cycles (result valid in the cycle enable is high).
// Backpressure: none; outputs are zero while enable is low.
module alu
    import alu_pkg::*;
#(
    parameter int SIZE = 4
) (
    input  logic              enable,
    input  logic [3:0]        command,
    input  logic [SIZE-1:0]   a,
    input  logic [SIZE-1:0]   b,
    output logic [2*SIZE-1:0] result,
    output logic              overflow
);

    logic [2*SIZE-1:0] za, zb, sa, sb;

    // zero-extended for unsigned ops, sign-extended for ADDS; overflow is relative to SIZE bits
    always_comb begin
        za       = {{SIZE{1'b0}}, a};
        zb       = {{SIZE{1'b0}}, b};
        sa       = {{SIZE{a[SIZE-1]}}, a};
        sb       = {{SIZE{b[SIZE-1]}}, b};
        result   = '0;
        overflow = 1'b0;
        if (enable) begin
            case (command)
                CMD_AND:  result = za & zb;
                CMD_OR:   result = za | zb;
                CMD_XOR:  result = za ^ zb;
                CMD_NOT:  result = {{SIZE{1'b0}}, ~a};
                CMD_ADDU: begin
                    result   = za + zb;
                    overflow = result[SIZE];
                end
                CMD_ADDS: begin
                    result   = sa + sb;
                    overflow = (a[SIZE-1] == b[SIZE-1]) && (result[SIZE-1] != a[SIZE-1]);
                end
                CMD_SUBU: begin
                    result   = za - zb;
                    overflow = (a < b);
                end
                default: begin
                    result   = '0;
                    overflow = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/wrap_counter.sv
// Free-running event counter that wraps to zero after its maximum value.
// Latency: count reflects an inc pulse one cycle later.
// Backpressure: none; every inc is counted.
module wrap_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // natural binary rollover gives the wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Accepts ALU requests, runs each through an external ALU for one cycle, returns a response.
// Latency: legal cmd -> response two cycles after accept, illegal cmd -> one cycle (no ALU cycle).
// Backpressure: response held until rsp_ready; req_ready follows rsp_ready in RESP. ALU_SEQ_ACC_EN adds an accumulator.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int SIZE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_cmd,
    input  logic [SIZE-1:0]   req_a,
    input  logic [SIZE-1:0]   req_b,
    input  logic              req_use_acc,
    output logic              alu_enable,
    output logic [3:0]        alu_command,
    output logic [SIZE-1:0]   alu_a,
    output logic [SIZE-1:0]   alu_b,
    input  logic              alu_overflow,
    input  logic [2*SIZE-1:0] alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [2*SIZE-1:0] rsp_result,
    output logic              rsp_overflow,
    output logic              rsp_err,
    output logic              sticky_ovf,
    input  logic              clr_sticky,
    output logic [7:0]        op_count
);

    seq_state_e      state_q, state_d;
    logic            legal;
    logic            accept;
    logic            rsp_hs;
    logic [SIZE-1:0] a_sel;

    assign legal  = (req_cmd <= ALU_CMD_MAX);
    assign accept = req_valid && req_ready;
    assign rsp_hs = rsp_valid && rsp_ready;

`ifdef ALU_SEQ_ACC_EN
    logic [SIZE-1:0] acc;

    // accumulator tracks the low half of every ALU result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (alu_enable) begin
            acc <= alu_result[SIZE-1:0];
        end
    end

    assign a_sel = req_use_acc ? acc : req_a;
`else
    logic unused_use_acc;
    assign unused_use_acc = req_use_acc;
    assign a_sel          = req_a;
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state and handshake/enable outputs; RESP can accept a new request in its handshake cycle
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        alu_enable = 1'b0;
        rsp_valid  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = legal ? ST_EXEC : ST_RESP;
                end
            end
            ST_EXEC: begin
                alu_enable = 1'b1;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                req_ready = rsp_ready;
                if (rsp_ready) begin
                    if (req_valid) begin
                        state_d = legal ? ST_EXEC : ST_RESP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // operand registers load only on legal accepts; response captured from ALU or forced for errors
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_command  <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            rsp_err      <= 1'b0;
        end else begin
            if (accept && legal) begin
                alu_command <= req_cmd;
                alu_a       <= a_sel;
                alu_b       <= req_b;
            end
            if (alu_enable) begin
                rsp_result   <= alu_result;
                rsp_overflow <= alu_overflow;
                rsp_err      <= 1'b0;
            end else if (accept && !legal) begin
                rsp_result   <= '0;
                rsp_overflow <= 1'b0;
                rsp_err      <= 1'b1;
            end
        end
    end

    // sticky overflow: a capture with overflow beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_ovf <= 1'b0;
        end else if (alu_enable && alu_overflow) begin
            sticky_ovf <= 1'b1;
        end else if (clr_sticky) begin
            sticky_ovf <= 1'b0;
        end
    end

    wrap_counter #(.WIDTH(8)) u_op_count (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rsp_hs),
        .count (op_count)
    );

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter: SIZE, 4, operand width in bits (result width 2*SIZE).
REQ-002 SHALL have port: clk  in  1  single clock, all state rising-edge.
REQ-003 SHALL have port: rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: req_valid in 1, req_ready out 1; request handshake.
REQ-005 SHALL have ports: req_cmd in 4, req_a in SIZE, req_b in SIZE, req_use_acc in 1; request payload.
REQ-006 SHALL have ports: alu_enable out 1, alu_command out 4, alu_a out SIZE, alu_b out SIZE; drive to the downstream ALU.
REQ-007 SHALL have ports: alu_overflow in 1, alu_result in 2*SIZE; combinational return from the ALU.
REQ-008 SHALL have ports: rsp_valid out 1, rsp_ready in 1, rsp_result out 2*SIZE, rsp_overflow out 1, rsp_err out 1; response handshake.
REQ-009 SHALL have ports: sticky_ovf out 1, clr_sticky in 1, op_count out 8; status.

Function
REQ-010 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-011 SHALL assert req_ready in IDLE, and in RESP when rsp_ready=1 (combinational path rsp_ready->req_ready); otherwise deassert it.
REQ-012 On accept with legal cmd (0x0-0x6: AND, OR, XOR, NOT, ADDU, ADDS, SUBU), SHALL register cmd/a/b and enter EXEC next cycle.
REQ-013 In EXEC, SHALL drive alu_enable=1 and the registered cmd/a/b for exactly one cycle, capture alu_result and alu_overflow at that cycle's end, and enter RESP.
REQ-014 Outside EXEC, SHALL hold alu_enable=0 and keep alu_command/alu_a/alu_b at their last registered values.
REQ-015 On accept with illegal cmd (0x7-0xF), SHALL enter RESP directly with rsp_err=1, rsp_result=0, rsp_overflow=0, with no EXEC cycle.
REQ-016 Latency: accept at edge N -> rsp_valid=1 from edge N+2 (legal cmd) or N+1 (illegal cmd).
REQ-017 In RESP, SHALL hold rsp_valid=1 and rsp_result/rsp_overflow/rsp_err stable until rsp_ready=1.
REQ-018 On response handshake, SHALL go to EXEC (new legal req accepted), RESP (new illegal req accepted), or IDLE (no request).
REQ-019 SHALL pass alu_result unchanged to rsp_result; no width or sign adjustment.
REQ-020 SHALL set sticky_ovf on every captured alu_overflow=1, and clear it on clr_sticky=1; if both occur in one cycle, set wins.
REQ-021 SHALL increment op_count by one on every response handshake, including err responses, wrapping 255->0.

Reset
REQ-022 On rst_n=0, SHALL immediately force: state IDLE, alu_enable 0, alu_command/alu_a/alu_b 0, rsp_valid 0, rsp_result 0, rsp_overflow 0, rsp_err 0, sticky_ovf 0, op_count 0, accumulator 0.
REQ-023 Reset mid-EXEC or mid-RESP SHALL discard the in-flight operation; no response follows reset release.

Configuration
REQ-024 With ALU_SEQ_ACC_EN defined, SHALL keep a SIZE-bit accumulator loaded with rsp_result[SIZE-1:0] at each non-err capture, and SHALL substitute it for req_a when req_use_acc=1 at accept.
REQ-025 Without ALU_SEQ_ACC_EN, SHALL omit the accumulator and ignore req_use_acc; the port remains present.

Structure
REQ-026 Package alu_pkg SHALL hold the command enum (AND=0 ... SUBU=6), ALU_CMD_MAX=6, and the FSM state typedef; the ALU module SHALL share this package.
REQ-027 The op counter SHALL be a sub-module wrap_counter (parameter WIDTH=8, inputs inc and rst_n); the ALU SHALL be instantiated beside, not inside, the sequencer.

Verification (SIZE=4, sequencer wired to alu)
REQ-028 SHALL cover: AND a=7 b=3 accepted at cycle 0 -> alu_enable high only in cycle 1; rsp_valid in cycle 2; rsp_result=0x03, rsp_overflow=0, rsp_err=0.
REQ-029 SHALL cover: ADDS a=7 b=1 -> rsp_overflow=1, rsp_result low nibble 0x8, sticky_ovf=1 from the next cycle; clr_sticky pulse -> sticky_ovf=0; clr_sticky in the same cycle as a capture with overflow -> sticky_ovf stays 1.
REQ-030 SHALL cover: rsp_ready held low 5 cycles -> rsp_valid and payload stable, req_ready=0, alu_enable=0 throughout.
REQ-031 SHALL cover: req_cmd=0x9 -> rsp_valid next cycle, rsp_err=1, rsp_result=0, alu_enable never asserted, op_count incremented.
REQ-032 SHALL cover: rst_n low during EXEC -> all outputs 0 at once; no rsp_valid after release; 256 back-to-back handshakes -> op_count wraps to 0.
REQ-033 SHALL cover, with ALU_SEQ_ACC_EN: ADDU 1+0, then use_acc=1 with b=2 -> alu_a=1 and rsp_result=0x03.
